// File: rtl/fetch_request_unit_if.sv
// Handshake bundle between the fetch request unit and its controller/memory side.
// The slave modport is the fetch_request_unit view; master is the driving environment.
interface fetch_request_unit_if;
   logic [1:0]  pc_sel;
   logic [31:0] load_addr;
   logic [31:0] jr_addr;
   logic        halt;
   logic        dren_req;
   logic        dwen_req;
   logic        ihit;
   logic        dhit;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] npc;
   logic        dmemREN;
   logic        dmemWEN;
   logic        halted;
   logic [31:0] stall_count;

   modport slave (
      input  pc_sel, load_addr, jr_addr, halt, dren_req, dwen_req, ihit, dhit,
      output imemREN, imemaddr, npc, dmemREN, dmemWEN, halted, stall_count
   );

   modport master (
      output pc_sel, load_addr, jr_addr, halt, dren_req, dwen_req, ihit, dhit,
      input  imemREN, imemaddr, npc, dmemREN, dmemWEN, halted, stall_count
   );
endinterface

// File: rtl/fetch_request_unit.sv
// PC sequencer issuing instruction fetches and registered data requests (FETCH/DATA/HALT).
// Optional memory-wait counter enabled by macro FETCH_STALL_COUNT_EN.
module fetch_request_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input logic                 CLK,
   input logic                 RST,
   fetch_request_unit_if.slave bus
);

   typedef enum logic [1:0] {StFetch, StData, StHalt} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] pc_d;
   logic        dmem_ren_q;
   logic        dmem_wen_q;
   logic        halted_q;

   assign pc_plus4 = pc_q + 32'd4;

   // Targets are word-aligned by forcing the low two bits to zero.
   always_comb begin
      pc_d = pc_plus4;
      unique case (bus.pc_sel)
         2'd0:    pc_d = {bus.load_addr[31:2], 2'b00};
         2'd1:    pc_d = {bus.jr_addr[31:2], 2'b00};
         default: pc_d = pc_plus4;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StFetch;
         pc_q       <= PC_INIT;
         dmem_ren_q <= 1'b0;
         dmem_wen_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (bus.ihit) begin
                  if (bus.halt) begin
                     state_q  <= StHalt;
                     halted_q <= 1'b1;
                  end else if (bus.dren_req || bus.dwen_req) begin
                     state_q    <= StData;
                     dmem_wen_q <= bus.dwen_req;
                     dmem_ren_q <= bus.dren_req & ~bus.dwen_req;
                  end else begin
                     pc_q <= pc_d;
                  end
               end
            end
            StData: begin
               if (bus.dhit) begin
                  state_q    <= StFetch;
                  dmem_ren_q <= 1'b0;
                  dmem_wen_q <= 1'b0;
                  pc_q       <= pc_d;
               end
            end
            StHalt: begin
               halted_q <= 1'b1;
            end
            default: begin
               state_q <= StFetch;
            end
         endcase
      end
   end

`ifdef FETCH_STALL_COUNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q <= 32'd0;
      end else if (((state_q == StFetch) && !bus.ihit) || ((state_q == StData) && !bus.dhit)) begin
         if (stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign bus.stall_count = stall_q;
`else
   assign bus.stall_count = 32'd0;
`endif

   assign bus.imemREN  = (state_q == StFetch);
   assign bus.imemaddr = pc_q;
   assign bus.npc      = pc_plus4;
   assign bus.dmemREN  = dmem_ren_q;
   assign bus.dmemWEN  = dmem_wen_q;
   assign bus.halted   = halted_q;

endmodule

// File: doc/fetch_request_unit.md
FETCH_REQUEST_UNIT -- requirements
Module: fetch_request_unit

Interface
REQ-001 PC_INIT, 32'h0000_0000, program counter value loaded on reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 pc_sel  input  2  next-PC select: 0 load_addr, 1 jr_addr, 2 pc+4, 3 reserved (treated as 2).
REQ-005 load_addr  input  32  branch/jump target.
REQ-006 jr_addr  input  32  register-indirect jump target.
REQ-007 halt  input  1  decoded halt for the current instruction.
REQ-008 dren_req, dwen_req  input  1 each  current instruction needs a data read or write.
REQ-009 ihit, dhit  input  1 each  instruction/data memory completion strobes.
REQ-010 imemREN  output  1  instruction fetch request.
REQ-011 imemaddr  output  32  current PC.
REQ-012 npc  output  32  PC+4; feeds the register write-back path for link.
REQ-013 dmemREN, dmemWEN  output  1 each  registered data memory requests.
REQ-014 halted  output  1  sticky halt indication.
REQ-015 stall_count  output  32  memory-wait cycle counter.

Function
REQ-016 The block SHALL implement FSM states FETCH, DATA, HALT; the reset state SHALL be FETCH.
REQ-017 The block SHALL drive imemREN=1 only in FETCH, and imemaddr=pc in all states.
REQ-018 The block SHALL drive npc = pc + 32'd4 combinationally, with modulo-2^32 wrap (FFFF_FFFC -> 0000_0000).
REQ-019 The next PC SHALL be chosen per pc_sel, with bits [1:0] of load_addr/jr_addr forced to 2'b00.
REQ-020 In FETCH with ihit=0, the block SHALL hold pc and state.
REQ-021 In FETCH with ihit=1 and halt=1, the block SHALL go to HALT, hold pc, and ignore dren_req/dwen_req; halt priority.
REQ-022 In FETCH with ihit=1, halt=0, and dren_req|dwen_req, the block SHALL go to DATA and set dmemWEN=dwen_req and dmemREN=dren_req&~dwen_req; write wins; pc held.
REQ-023 In FETCH with ihit=1, halt=0, and no data request, the block SHALL load the next PC at that edge; one-cycle latency from ihit.
REQ-024 In DATA, the block SHALL hold dmemREN/dmemWEN stable until dhit.
REQ-025 In DATA on dhit=1, the block SHALL clear both data strobes, load the next PC using pc_sel/targets sampled that cycle, and return to FETCH at the same edge.
REQ-026 Upstream SHALL keep pc_sel, targets, and request inputs stable while in DATA; the block SHALL not latch them.
REQ-027 The block SHALL ignore ihit outside FETCH and dhit outside DATA.
REQ-028 In HALT, the block SHALL assert halted=1, drive all memory requests 0, and hold pc; only RST exits.
REQ-029 The block SHALL never assert dmemREN and dmemWEN together, nor imemREN together with either.

Reset
REQ-030 When RST=1 at an edge, the block SHALL set pc=PC_INIT, state=FETCH, dmemREN=0, dmemWEN=0, halted=0, and stall_count=0, from any state including mid-DATA.
REQ-031 During the cycle after reset, the block SHALL drive imemREN=1 and imemaddr=PC_INIT.

Configuration
REQ-032 With macro FETCH_STALL_COUNT_EN defined, stall_count SHALL increment once per cycle in FETCH with ihit=0 or in DATA with dhit=0, saturating at FFFF_FFFF.
REQ-033 Without FETCH_STALL_COUNT_EN, stall_count SHALL be constant 0, with no counter logic synthesized; the port remains present.

Verification
REQ-034 Reset then ihit on the 3rd cycle with pc_sel=2 -> imemaddr goes 0000_0000 -> 0000_0004 one edge after ihit; stall_count=2 with the macro, 0 without.
REQ-035 Load: ihit with dren_req=1, pc_sel=2 -> dmemREN=1 next cycle, held 4 cycles until dhit, then dmemREN=0 and pc=+4 at the same edge; imemREN=0 throughout DATA.
REQ-036 ihit with pc_sel=1, jr_addr=0000_1237 -> pc=0000_1234; pc_sel=0, load_addr=0000_0040 -> pc=0000_0040; pc=FFFF_FFFC, pc_sel=2 -> pc=0000_0000.
REQ-037 ihit with halt=1 and dwen_req=1 -> HALT; halted=1, dmemWEN stays 0, pc frozen; later ihit/dhit pulses have no effect.
REQ-038 RST asserted during DATA with dmemWEN=1 -> next cycle dmemWEN=0, state FETCH, pc=PC_INIT; both dren_req and dwen_req on ihit -> only dmemWEN=1.
